wb_copy_master: RTL and testbench
=================================

# wb_copy_master

Wishbone classic-cycle initiator that copies a block of 32-bit words from a source address to a destination address over a single master port. It is the bus-master counterpart to the dual-port wishbone RAM and peripherals: it drives `cyc/stb/we/sel/addr/dat` and consumes `ack/err/dat`. Software-visible control (start, addresses, length) arrives from a register block or testbench. Status returns as busy, done and error indications.

## Interface
- `LEN_WIDTH`, 16, width of the word-count input; max copy is 2^LEN_WIDTH−1 words.
- `TIMEOUT`, 255, cycles a single access may wait for `ack`/`err` before abort; must be ≥1.

- `clk_i` in 1: single clock; all logic on rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `start_i` in 1: begin copy; sampled only when idle.
- `src_i` in 32: source byte address; bits [1:0] ignored.
- `dst_i` in 32: destination byte address; bits [1:0] ignored.
- `len_i` in LEN_WIDTH: number of words to copy.
- `busy_o` out 1: copy in progress.
- `done_o` out 1: one-cycle pulse on completion or abort.
- `err_o` out 1: last copy aborted; valid with `done_o`, held until next accepted start.
- `remain_o` out LEN_WIDTH: words not yet written.
- `wbm_addr_o` out 32: bus address, always word-aligned (bits [1:0]=0).
- `wbm_dat_o` out 32: write data.
- `wbm_sel_o` out 4: byte selects; 4'hF on writes, 4'hF on reads.
- `wbm_cyc_o`, `wbm_stb_o` out 1: cycle/strobe, always equal.
- `wbm_we_o` out 1: write enable.
- `wbm_dat_i` in 32: read data, valid when `wbm_ack_i`.
- `wbm_ack_i`, `wbm_err_i` in 1: access termination.

## Operation
- States: IDLE, READ, WRITE. Status registers track the DONE/ERR pulse outside the FSM.
- IDLE: `start_i`=1 latches `src_i[31:2]`, `dst_i[31:2]`, `len_i`, and clears `err_o`.
  - If `len_i`=0: no bus activity. `done_o` pulses next cycle, `busy_o` stays 0.
  - Otherwise: go to READ.
- READ: `cyc=stb=1`, `we=0`, `addr={src,2'b00}`.
  - On `ack`: latch `wbm_dat_i` into the data buffer and go to WRITE.
- WRITE: `cyc=stb=1`, `we=1`, `sel=4'hF`, `addr={dst,2'b00}`, `dat`=buffer.
  - On `ack`: src+=1, dst+=1 (word units, wrap mod 2^30), remain−=1.
  - If remain becomes 0: go to IDLE and pulse `done_o`. Otherwise go to READ.
- `ack` and `err` both high: treat as `err`.
- `err` in READ or WRITE: drop `cyc/stb` next cycle, go to IDLE, pulse `done_o`, set `err_o`=1. `remain_o` freezes at its value.
- Timeout: a per-access counter resets on entry to READ/WRITE and counts while no `ack`/`err`. Reaching TIMEOUT behaves exactly like `err`.
- `start_i` while busy: ignored; latched parameters unchanged.
- Bus outputs when not in READ/WRITE: `cyc=stb=we=0`, `sel=0`, `addr`/`dat` hold last value.

## Timing
- Reset values: `busy_o`=0, `done_o`=0, `err_o`=0, `remain_o`=0, `wbm_cyc_o`=`wbm_stb_o`=`wbm_we_o`=0, `wbm_sel_o`=0, `wbm_addr_o`=0, `wbm_dat_o`=0.
- Reset asserted mid-copy: bus strobes drop immediately (asynchronous); copy state is lost.
- Start accepted at edge E: `busy_o`=1 and READ strobe visible in cycle E+1.
- `ack` is sampled at the clock edge. A slave that acks combinationally in the same cycle as `stb` gives 1 cycle per access.
- With a zero-wait slave, N words take 2N bus cycles. READ and WRITE strobes are back-to-back; `cyc` may stay high across the read→write boundary.
- A slave with W wait states costs W+1 cycles per access.
- Final write ack at edge F: in cycle F+1, `done_o`=1, `busy_o`=0, `cyc`=0. A new start can be accepted at edge F+1.
- Timeout: with no response, abort is taken at the edge where the wait counter equals TIMEOUT. Strobes drop the cycle after.

## Test plan
- Zero-wait RAM, src=0x100, dst=0x200, len=4, words 0x11111111..0x44444444 → dst holds the same 4 words; `done_o` 8 cycles after the first strobe; `err_o`=0; `remain_o`=0.
- Unaligned src=0x103, dst=0x207, len=1 → bus addresses 0x100 (read) and 0x204 (write).
- len=0 → no `cyc` ever asserted; `done_o` pulses one cycle after start; `busy_o` never rises.
- Slave asserts `err` on the 2nd read of len=3 → `done_o`+`err_o`=1; exactly one write issued; `remain_o`=2.
- TIMEOUT=4 with a slave that never acks → abort with `err_o`=1 after 4 wait cycles; then a start against a good slave copies correctly and clears `err_o`.
- Second start pulse mid-copy is ignored. Address wrap: src=0xFFFFFFFC, len=2 → second read at 0x00000000. `rst_ni` low mid-WRITE → `cyc`/`stb` drop immediately.

Source files
------------

// File: rtl/wb_copy_master.sv
// Wishbone classic-cycle block copier: read one word, write it, repeat until len words moved or a bus error/timeout.
// Start to first strobe is 1 cycle; each access holds cyc/stb until ack/err/timeout; done_o pulses the cycle after the last termination.
module wb_copy_master #(
  parameter int LEN_WIDTH = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [31:0]          src_i,
  input  logic [31:0]          dst_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [LEN_WIDTH-1:0] remain_o,
  output logic [31:0]          wbm_addr_o,
  output logic [31:0]          wbm_dat_o,
  output logic [3:0]           wbm_sel_o,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic                 wbm_we_o,
  input  logic [31:0]          wbm_dat_i,
  input  logic                 wbm_ack_i,
  input  logic                 wbm_err_i
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

  state_e               state_q, state_d;
  logic [29:0]          src_q, src_d, dst_q, dst_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic [31:0]          addr_q, addr_d, dat_q, dat_d;
  logic                 done_q, done_d, err_q, err_d;
  logic [TW-1:0]        wait_q, wait_d;
  logic                 abort;
  logic                 unused_lsbs;

  assign unused_lsbs = ^{src_i[1:0], dst_i[1:0]};

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    dat_d   = dat_q;
    done_d  = 1'b0;
    err_d   = err_q;
    wait_d  = wait_q;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          src_d = src_i[31:2];
          dst_d = dst_i[31:2];
          rem_d = len_i;
          err_d = 1'b0;
          if (len_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = READ;
            addr_d  = {src_i[31:2], 2'b00};
            wait_d  = '0;
          end
        end
      end
      READ, WRITE: begin
        // A timeout is indistinguishable from a slave error, and error beats a simultaneous ack.
        abort = wbm_err_i || (wait_q == TW'(TIMEOUT));
        if (abort) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (wbm_ack_i) begin
          wait_d = '0;
          if (state_q == READ) begin
            state_d = WRITE;
            dat_d   = wbm_dat_i;
            addr_d  = {dst_q, 2'b00};
          end else begin
            src_d = src_q + 30'd1;
            dst_d = dst_q + 30'd1;
            rem_d = rem_q - LEN_WIDTH'(1);
            if (rem_q == LEN_WIDTH'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = READ;
              addr_d  = {src_q + 30'd1, 2'b00};
            end
          end
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      addr_q  <= '0;
      dat_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      dat_q   <= dat_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
    end
  end

  // Strobes decode straight from the state register so an async reset drops them at once.
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign remain_o   = rem_q;
  assign wbm_cyc_o  = busy_o;
  assign wbm_stb_o  = busy_o;
  assign wbm_we_o   = (state_q == WRITE);
  assign wbm_sel_o  = busy_o ? 4'hF : 4'h0;
  assign wbm_addr_o = addr_q;
  assign wbm_dat_o  = dat_q;

endmodule

// File: tb/tb_wb_copy_master.sv
// Directed bench for wb_copy_master against a combinational-ack slave whose read data is a function of address.
module tb_wb_copy_master;

  logic        clk_i, rst_ni, start_i;
  logic [31:0] src_i, dst_i;
  logic [15:0] len_i, remain_o;
  logic        busy_o, done_o, err_o;
  logic [31:0] wbm_addr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i, wbm_err_i;

  int passed = 0;
  int total  = 0;
  int mode   = 0;   // 0: zero-wait ack, 1: never respond, 2: err on read number err_at
  int err_at = -1;
  int rd_cnt = 0;
  logic        err_hit;
  logic [31:0] acc_addr[$];
  logic [31:0] acc_dat[$];
  logic        acc_we[$];

  wb_copy_master #(.LEN_WIDTH(16), .TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .src_i(src_i), .dst_i(dst_i),
    .len_i(len_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .remain_o(remain_o),
    .wbm_addr_o(wbm_addr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return 32'h11111111 * ({28'd0, a[5:2]} + 32'd1);
  endfunction

  assign err_hit   = (mode == 2) && !wbm_we_o && (rd_cnt == err_at);
  assign wbm_ack_i = wbm_cyc_o && wbm_stb_o && ((mode == 0) || ((mode == 2) && !err_hit));
  assign wbm_err_i = wbm_cyc_o && wbm_stb_o && err_hit;
  assign wbm_dat_i = rd_word(wbm_addr_o);

  always @(posedge clk_i) begin
    if (wbm_cyc_o && (wbm_ack_i || wbm_err_i)) begin
      acc_addr.push_back(wbm_addr_o);
      acc_dat.push_back(wbm_dat_o);
      acc_we.push_back(wbm_we_o);
      if (!wbm_we_o) rd_cnt <= rd_cnt + 1;
    end
  end

  // Called #1 after a rising edge; returns #1 after the edge that accepted start.
  task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    src_i = s; dst_i = d; len_i = l; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done_o && n < 50) begin
      @(posedge clk_i); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    total++; if ({busy_o, done_o, err_o} !== 3'b000) $display("FAIL reset_status got %b want 000", {busy_o, done_o, err_o}); else passed++;
    total++; if (remain_o !== 16'd0) $display("FAIL reset_remain got %0h want 0", remain_o); else passed++;
    total++; if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o} !== 7'd0) $display("FAIL reset_bus got %b want 0", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}); else passed++;
    total++; if ({wbm_addr_o, wbm_dat_o} !== 64'd0) $display("FAIL reset_addr_dat got %h want 0", {wbm_addr_o, wbm_dat_o}); else passed++;
  endtask

  task automatic test_copy();
    int n, base;
    logic [31:0] exp_w[4];
    exp_w = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    base = acc_addr.size();
    do_start(32'h100, 32'h200, 16'd4);
    total++; if ({busy_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o} !== 8'b1110_1111) $display("FAIL copy_first_strobe got %b want 11101111", {busy_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}); else passed++;
    total++; if (wbm_addr_o !== 32'h100) $display("FAIL copy_first_addr got %h want 00000100", wbm_addr_o); else passed++;
    wait_done(n);
    total++; if (n !== 8) $display("FAIL copy_latency got %0d want 8", n); else passed++;
    total++; if ({busy_o, wbm_cyc_o, err_o} !== 3'b000) $display("FAIL copy_end_status got %b want 000", {busy_o, wbm_cyc_o, err_o}); else passed++;
    total++; if (remain_o !== 16'd0) $display("FAIL copy_remain got %0d want 0", remain_o); else passed++;
    total++; if (acc_addr.size() !== base + 8) $display("FAIL copy_access_count got %0d want 8", acc_addr.size() - base); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (acc_we[base+2*i+1] !== 1'b1 || acc_addr[base+2*i+1] !== 32'h200 + 32'(4*i) || acc_dat[base+2*i+1] !== exp_w[i])
        $display("FAIL copy_write%0d got we=%b addr=%h dat=%h want addr=%h dat=%h", i, acc_we[base+2*i+1], acc_addr[base+2*i+1], acc_dat[base+2*i+1], 32'h200 + 32'(4*i), exp_w[i]);
      else passed++;
    end
    @(posedge clk_i); #1;
    total++; if (done_o !== 1'b0) $display("FAIL copy_done_pulse got %b want 0", done_o); else passed++;
  endtask

  task automatic test_unaligned();
    int n, base;
    base = acc_addr.size();
    do_start(32'h103, 32'h207, 16'd1);
    wait_done(n);
    total++; if (acc_addr[base] !== 32'h100) $display("FAIL unaligned_read_addr got %h want 00000100", acc_addr[base]); else passed++;
    total++; if (acc_addr[base+1] !== 32'h204 || acc_dat[base+1] !== 32'h11111111) $display("FAIL unaligned_write got %h/%h want 00000204/11111111", acc_addr[base+1], acc_dat[base+1]); else passed++;
  endtask

  task automatic test_len0();
    int base;
    logic seen;
    base = acc_addr.size();
    do_start(32'h10, 32'h20, 16'd0);
    total++; if ({done_o, busy_o, wbm_cyc_o} !== 3'b100) $display("FAIL len0_pulse got %b want 100", {done_o, busy_o, wbm_cyc_o}); else passed++;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i); #1;
      seen = seen | wbm_cyc_o | busy_o | done_o;
    end
    total++; if (seen !== 1'b0 || acc_addr.size() !== base) $display("FAIL len0_no_bus got %b/%0d want 0/0", seen, acc_addr.size() - base); else passed++;
  endtask

  task automatic test_err();
    int n, base, writes;
    mode = 2; err_at = rd_cnt + 1;
    base = acc_addr.size();
    do_start(32'h300, 32'h400, 16'd3);
    wait_done(n);
    total++; if (n !== 3) $display("FAIL err_latency got %0d want 3", n); else passed++;
    total++; if ({done_o, err_o, busy_o, wbm_cyc_o} !== 4'b1100) $display("FAIL err_status got %b want 1100", {done_o, err_o, busy_o, wbm_cyc_o}); else passed++;
    total++; if (remain_o !== 16'd2) $display("FAIL err_remain got %0d want 2", remain_o); else passed++;
    writes = 0;
    for (int i = base; i < acc_we.size(); i++) writes += int'(acc_we[i]);
    total++; if (writes !== 1) $display("FAIL err_writes got %0d want 1", writes); else passed++;
    @(posedge clk_i); #1;
    total++; if ({done_o, err_o, remain_o} !== {2'b01, 16'd2}) $display("FAIL err_hold got %b/%0d want 01/2", {done_o, err_o}, remain_o); else passed++;
    mode = 0;
  endtask

  task automatic test_timeout();
    int n, base;
    mode = 1;
    do_start(32'h500, 32'h600, 16'd2);
    wait_done(n);
    total++; if (n !== 5) $display("FAIL timeout_latency got %0d want 5", n); else passed++;
    total++; if ({err_o, wbm_cyc_o, remain_o} !== {2'b10, 16'd2}) $display("FAIL timeout_status got %b/%0d want 10/2", {err_o, wbm_cyc_o}, remain_o); else passed++;
    mode = 0;
    base = acc_addr.size();
    do_start(32'h500, 32'h600, 16'd2);
    total++; if ({err_o, busy_o} !== 2'b01) $display("FAIL timeout_err_clear got %b want 01", {err_o, busy_o}); else passed++;
    wait_done(n);
    total++; if (n !== 4 || err_o !== 1'b0) $display("FAIL timeout_recover got n=%0d err=%b want 4/0", n, err_o); else passed++;
    total++; if (acc_addr[base+3] !== 32'h604 || acc_dat[base+3] !== 32'h22222222) $display("FAIL timeout_recover_data got %h/%h want 00000604/22222222", acc_addr[base+3], acc_dat[base+3]); else passed++;
  endtask

  task automatic test_busy_start();
    int n, base;
    base = acc_addr.size();
    do_start(32'h700, 32'h800, 16'd3);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    do_start(32'h900, 32'hA00, 16'd5);
    wait_done(n);
    total++; if (n !== 3 || acc_addr.size() !== base + 6) $display("FAIL busy_start_len got n=%0d acc=%0d want 3/6", n, acc_addr.size() - base); else passed++;
    total++; if (acc_addr[base+5] !== 32'h808 || acc_addr[base+4] !== 32'h708) $display("FAIL busy_start_addr got %h/%h want 00000708/00000808", acc_addr[base+4], acc_addr[base+5]); else passed++;
  endtask

  task automatic test_wrap();
    int n, base;
    base = acc_addr.size();
    do_start(32'hFFFFFFFC, 32'h40, 16'd2);
    wait_done(n);
    total++; if (acc_addr[base+2] !== 32'h0) $display("FAIL wrap_read_addr got %h want 00000000", acc_addr[base+2]); else passed++;
    total++; if (acc_dat[base+1] !== 32'h11111110 || acc_dat[base+3] !== 32'h11111111 || acc_addr[base+3] !== 32'h44)
      $display("FAIL wrap_writes got %h/%h@%h want 11111110/11111111@00000044", acc_dat[base+1], acc_dat[base+3], acc_addr[base+3]);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int k;
    do_start(32'h100, 32'h200, 16'd4);
    k = 0;
    while (!wbm_we_o && k < 10) begin
      @(posedge clk_i); #1;
      k++;
    end
    total++; if (wbm_we_o !== 1'b1) $display("FAIL rstmid_reach_write got %b want 1", wbm_we_o); else passed++;
    #1 rst_ni = 1'b0;
    #1;
    total++; if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, busy_o} !== 4'b0000) $display("FAIL rstmid_drop got %b want 0000", {wbm_cyc_o, wbm_stb_o, wbm_we_o, busy_o}); else passed++;
    total++; if (remain_o !== 16'd0) $display("FAIL rstmid_remain got %0d want 0", remain_o); else passed++;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; src_i = '0; dst_i = '0; len_i = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    test_reset();
    test_copy();
    test_unaligned();
    test_len0();
    test_err();
    test_timeout();
    test_busy_start();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
